// File: rtl/button_input_ctrl_if.sv
// Front-panel bus between button_input_ctrl and the rest of the clock design:
// raw buttons/switches in, conditioned pulses, switch vector and MODE out.
interface button_input_ctrl_if #(
    parameter int unsigned N_BTN = 5
);
    logic [N_BTN-1:0] BTN;
    logic [9:0]       SW;
    logic             alarm_ringing;
    logic [3:0]       MODE;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_long;
    logic [9:0]       minigame;
    logic             alarm_dismiss;

    modport master (
        output BTN, SW, alarm_ringing,
        input  MODE, btn_press, btn_long, minigame, alarm_dismiss
    );

    modport slave (
        input  BTN, SW, alarm_ringing,
        output MODE, btn_press, btn_long, minigame, alarm_dismiss
    );
endinterface

// File: rtl/button_input_ctrl.sv
// Front-panel input conditioner: synchronizes and debounces buttons and switches,
// generates press/long-press/dismiss pulses and owns the one-hot MODE state machine.
module button_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned LONG_CYC     = 50_000_000,
    parameter int unsigned N_BTN        = 5
) (
    input logic                 MCLK,
    input logic                 RESETN,
    button_input_ctrl_if.slave  bus
);
    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned LG_W = $clog2(LONG_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYC - 1);
    localparam logic [LG_W-1:0] LG_SAT  = LG_W'(LONG_CYC);

    typedef enum logic [3:0] {
        MODE_CLOCK     = 4'b0001,
        MODE_ALARM_SET = 4'b0010,
        MODE_STOPWATCH = 4'b0100,
        MODE_MINIGAME  = 4'b1000
    } mode_e;

    logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [9:0]       sw_s1_q, sw_s2_q;

    logic [DB_W-1:0]  db_cnt_q [N_BTN];
    logic [DB_W-1:0]  db_cnt_d [N_BTN];
    logic [LG_W-1:0]  hold_q   [N_BTN];
    logic [LG_W-1:0]  hold_d   [N_BTN];
    logic [N_BTN-1:0] stable_q, stable_d, stable_prev_q;

    logic [DB_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [9:0]       sw_sample_q, sw_sample_d;
    logic [9:0]       minigame_q, minigame_d;

    mode_e            state_q, state_d;

    logic [N_BTN-1:0] press, long_pulse;
    logic             tick;

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            db_cnt_q      <= '{default: '0};
            hold_q        <= '{default: '0};
            stable_q      <= '0;
            stable_prev_q <= '0;
            tick_cnt_q    <= '0;
            sw_sample_q   <= '0;
            minigame_q    <= '0;
            state_q       <= MODE_CLOCK;
        end else begin
            btn_s1_q      <= bus.BTN;
            btn_s2_q      <= btn_s1_q;
            sw_s1_q       <= bus.SW;
            sw_s2_q       <= sw_s1_q;
            db_cnt_q      <= db_cnt_d;
            hold_q        <= hold_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            tick_cnt_q    <= tick_cnt_d;
            sw_sample_q   <= sw_sample_d;
            minigame_q    <= minigame_d;
            state_q       <= state_d;
        end
    end

    // Debounce and hold timing per button; the hold counter parks one past
    // LONG_CYC-1 so the long pulse cannot repeat until release.
    always_comb begin
        db_cnt_d   = '{default: '0};
        hold_d     = '{default: '0};
        stable_d   = stable_q;
        long_pulse = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (btn_s2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            if (stable_q[i]) begin
                hold_d[i] = (hold_q[i] == LG_SAT) ? hold_q[i] : hold_q[i] + 1'b1;
            end
            long_pulse[i] = stable_q[i] && (hold_q[i] == LG_LAST);
        end
    end

    assign press = stable_q & ~stable_prev_q;

    // Switches are accepted only when two consecutive tick samples agree.
    always_comb begin
        tick        = (tick_cnt_q == DB_LAST);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        sw_sample_d = sw_sample_q;
        minigame_d  = minigame_q;
        if (tick) begin
            sw_sample_d = sw_s2_q;
            if (sw_s2_q == sw_sample_q) begin
                minigame_d = sw_s2_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.alarm_ringing) begin
            if (long_pulse[0]) begin
                state_d = MODE_CLOCK;
            end else if (press[0]) begin
                unique case (state_q)
                    MODE_CLOCK:     state_d = MODE_ALARM_SET;
                    MODE_ALARM_SET: state_d = MODE_STOPWATCH;
                    MODE_STOPWATCH: state_d = MODE_MINIGAME;
                    MODE_MINIGAME:  state_d = MODE_CLOCK;
                    default:        state_d = MODE_CLOCK;
                endcase
            end
        end
    end

    assign bus.MODE          = state_q;
    assign bus.btn_press     = press;
    assign bus.btn_long      = long_pulse;
    assign bus.minigame      = minigame_q;
    assign bus.alarm_dismiss = bus.alarm_ringing & (|press);
endmodule

// File: tb/tb_button_input_ctrl.sv
// Scoreboard bench for button_input_ctrl with short debounce/long-press timing.
module tb_button_input_ctrl;
    localparam int unsigned TB_DB   = 4;
    localparam int unsigned TB_LONG = 20;
    localparam int unsigned LAT     = 2 + TB_DB;

    typedef struct {
        int unsigned lo;
        int unsigned hi;
        logic [4:0]  press;
        logic [4:0]  lng;
        logic        dis;
        logic [3:0]  mode;
        logic [9:0]  mg;
    } evt_t;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    evt_t sb[$];
    evt_t mon_e;
    logic mon_en = 1'b0;
    logic [3:0] prev_mode = 4'b0001;
    logic [9:0] prev_mg = '0;
    logic [3:0] exp_mode;
    logic [9:0] exp_mg;

    button_input_ctrl_if #(.N_BTN(5)) bus();

    button_input_ctrl #(
        .DEBOUNCE_CYC(TB_DB),
        .LONG_CYC(TB_LONG),
        .N_BTN(5)
    ) dut (
        .MCLK(clk),
        .RESETN(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned lo, input int unsigned hi, input logic [4:0] p,
                        input logic [4:0] l, input logic d, input logic [3:0] m, input logic [9:0] g);
        evt_t e;
        e.lo = lo; e.hi = hi; e.press = p; e.lng = l; e.dis = d; e.mode = m; e.mg = g;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] next_mode(input logic [3:0] m);
        return (m == 4'b1000) ? 4'b0001 : {m[2:0], 1'b0};
    endfunction

    // Clean press of button idx held for hold cycles, followed by release and settling.
    task automatic press_btn(input int unsigned idx, input int unsigned hold);
        int unsigned n;
        logic ring;
        logic [4:0] mask;
        n = cyc;
        ring = bus.alarm_ringing;
        mask = 5'(1) << idx;
        bus.BTN[idx] = 1'b1;
        push(n + LAT, n + LAT, mask, '0, ring, exp_mode, exp_mg);
        if (idx == 0 && !ring) begin
            exp_mode = next_mode(exp_mode);
            push(n + LAT + 1, n + LAT + 1, '0, '0, 1'b0, exp_mode, exp_mg);
        end
        if (hold >= TB_LONG) begin
            push(n + LAT + TB_LONG - 1, n + LAT + TB_LONG - 1, '0, mask, 1'b0, exp_mode, exp_mg);
            if (idx == 0 && !ring && exp_mode != 4'b0001) begin
                exp_mode = 4'b0001;
                push(n + LAT + TB_LONG, n + LAT + TB_LONG, '0, '0, 1'b0, exp_mode, exp_mg);
            end
        end
        tick(hold);
        bus.BTN[idx] = 1'b0;
        tick(LAT + 4);
    endtask

    always @(negedge clk) begin
        if (mon_en && ((bus.btn_press | bus.btn_long) != '0 || bus.alarm_dismiss ||
                       bus.MODE != prev_mode || bus.minigame != prev_mg)) begin
            if (sb.size() == 0) begin
                check($sformatf("spurious_evt@%0d", cyc), sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("evt_window@%0d[%0d..%0d]", cyc, mon_e.lo, mon_e.hi),
                      32'(cyc >= mon_e.lo && cyc <= mon_e.hi), 1);
                check("btn_press", bus.btn_press, mon_e.press);
                check("btn_long", bus.btn_long, mon_e.lng);
                check("alarm_dismiss", bus.alarm_dismiss, mon_e.dis);
                check("mode", bus.MODE, mon_e.mode);
                check("minigame", bus.minigame, mon_e.mg);
            end
        end
        prev_mode = bus.MODE;
        prev_mg   = bus.minigame;
    end

    initial begin
        int unsigned n;
        rst_n = 1'b0;
        bus.alarm_ringing = 1'b0;
        bus.BTN = 5'($urandom);
        bus.SW  = 10'($urandom);
        tick(3);
        bus.BTN = 5'($urandom);
        bus.SW  = 10'($urandom);
        tick(3);
        check("rst_mode", bus.MODE, 4'b0001);
        check("rst_press", bus.btn_press, '0);
        check("rst_long", bus.btn_long, '0);
        check("rst_dismiss", bus.alarm_dismiss, 1'b0);
        check("rst_minigame", bus.minigame, '0);

        bus.BTN = '0;
        bus.SW  = '0;
        tick(2);
        rst_n = 1'b1;
        exp_mode = 4'b0001;
        exp_mg = '0;
        mon_en = 1'b1;
        tick(50);
        check("idle_mode", bus.MODE, 4'b0001);
        check("idle_minigame", bus.minigame, '0);

        // Bounce on BTN[0], then a clean hold: one press, MODE -> ALARM_SET.
        for (int k = 0; k < 3; k++) begin
            bus.BTN[0] = 1'b1;
            tick(2);
            bus.BTN[0] = 1'b0;
            tick(2);
        end
        press_btn(0, 12);
        check("bounce_mode", bus.MODE, 4'b0010);

        bus.BTN[1] = 1'b1;
        tick(3);
        bus.BTN[1] = 1'b0;
        tick(12);

        // Wrap through all four modes, then one more to reach STOPWATCH.
        repeat (5) press_btn(0, 8);
        check("wrap_mode", bus.MODE, 4'b0100);

        press_btn(0, 40);
        check("long_mode", bus.MODE, 4'b0001);

        bus.alarm_ringing = 1'b1;
        press_btn(2, 8);
        press_btn(0, 8);
        check("ring_mode", bus.MODE, 4'b0001);
        bus.alarm_ringing = 1'b0;
        tick(2);
        press_btn(0, 8);
        check("post_alarm_mode", bus.MODE, 4'b0010);

        n = cyc;
        bus.SW = 10'h2A5;
        exp_mg = 10'h2A5;
        push(n + 2, n + 2 + 2 * TB_DB, '0, '0, 1'b0, exp_mode, exp_mg);
        tick(14);
        bus.SW = 10'h2A5 ^ 10'h008;
        tick(1);
        bus.SW = 10'h2A5;
        tick(14);
        check("sw_minigame", bus.minigame, 10'h2A5);

        // Reset in the middle of a BTN[4] hold; button stays down through release.
        n = cyc;
        bus.BTN[4] = 1'b1;
        push(n + LAT, n + LAT, 5'b10000, '0, 1'b0, exp_mode, exp_mg);
        tick(15);
        check("hold_press_seen", sb.size(), 0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_mode", bus.MODE, 4'b0001);
        check("midrst_press", bus.btn_press, '0);
        check("midrst_long", bus.btn_long, '0);
        check("midrst_dismiss", bus.alarm_dismiss, 1'b0);
        check("midrst_minigame", bus.minigame, '0);
        tick(6);
        check("inrst_long", bus.btn_long, '0);
        bus.SW = '0;
        exp_mode = 4'b0001;
        exp_mg = '0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        press_btn(4, 30);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
